arithmetic_unit: RTL and testbench

- Registered unsigned arithmetic slice of the 16-bit ALU: add, subtract, multiply, divide, selected by a 2-bit function code.
- Sits beside the logic, shift and compare units under the ALU top, which drives the shared operands and the per-unit enable.
- Result, carry/overflow and valid flag are registered: one clock of latency.

---
 rtl/arithmetic_unit_pkg.sv | 11 +
 rtl/arithmetic_unit.sv | 87 ++++++++
 tb/tb_arithmetic_unit.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/arithmetic_unit_pkg.sv
// Shared ALU definitions: arithmetic function codes and the default datapath width.
package arithmetic_unit_pkg;

    localparam int ALU_WIDTH = 16;

    localparam logic [1:0] ARITH_ADD = 2'b00;
    localparam logic [1:0] ARITH_SUB = 2'b01;
    localparam logic [1:0] ARITH_MUL = 2'b10;
    localparam logic [1:0] ARITH_DIV = 2'b11;

endpackage

// File: rtl/arithmetic_unit.sv
// Registered unsigned add/sub/mul/div slice of the ALU. Combinational evaluation
// of the selected function feeds a single output register stage (one clock latency).
module arithmetic_unit
    import arithmetic_unit_pkg::*;
#(
    parameter int IN1_WIDTH       = ALU_WIDTH,
    parameter int IN2_WIDTH       = ALU_WIDTH,
    parameter int ARITH_OUT_WIDTH = ALU_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [IN1_WIDTH-1:0]       in1,
    input  logic [IN2_WIDTH-1:0]       in2,
    input  logic [1:0]                 arith_fun,
    input  logic                       arith_en,
    output logic [ARITH_OUT_WIDTH-1:0] arith_out,
    output logic                       arith_cout,
    output logic                       arith_flag
);

    localparam int W  = (IN1_WIDTH > IN2_WIDTH) ? IN1_WIDTH : IN2_WIDTH;
    // Internal width holds the full product and still leaves room above the output width.
    localparam int XW = (2 * W > ARITH_OUT_WIDTH + 1) ? 2 * W : ARITH_OUT_WIDTH + 1;

    logic [XW-1:0]              a_p0;
    logic [XW-1:0]              b_p0;
    logic [XW-1:0]              wide_p0;
    logic [ARITH_OUT_WIDTH-1:0] res_p0;
    logic                       cout_p0;

    // Guarded divide: all ones when the divisor is zero, so nothing undefined reaches the register.
    function automatic logic [XW-1:0] safe_div(input logic [XW-1:0] num, input logic [XW-1:0] den);
        if (den == '0)
            return '1;
        return num / den;
    endfunction

    function automatic logic above_out(input logic [XW-1:0] val);
        return |(val >> ARITH_OUT_WIDTH);
    endfunction

    assign a_p0 = XW'(in1);
    assign b_p0 = XW'(in2);

    // Stage p0: combinational evaluation of the selected function
    always_comb begin
        wide_p0 = '0;
        cout_p0 = 1'b0;
        case (arith_fun)
            ARITH_ADD: begin
                wide_p0 = a_p0 + b_p0;
                cout_p0 = above_out(wide_p0);
            end
            ARITH_SUB: begin
                wide_p0 = a_p0 - b_p0;
                cout_p0 = (a_p0 < b_p0);
            end
            ARITH_MUL: begin
                wide_p0 = a_p0 * b_p0;
                cout_p0 = above_out(wide_p0);
            end
            default: begin
                wide_p0 = safe_div(a_p0, b_p0);
                cout_p0 = (b_p0 == '0);
            end
        endcase
        res_p0 = wide_p0[ARITH_OUT_WIDTH-1:0];
    end

    // Stage p1: output register; a disabled edge clears everything
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arith_out  <= '0;
            arith_cout <= 1'b0;
            arith_flag <= 1'b0;
        end else if (arith_en) begin
            arith_out  <= res_p0;
            arith_cout <= cout_p0;
            arith_flag <= 1'b1;
        end else begin
            arith_out  <= '0;
            arith_cout <= 1'b0;
            arith_flag <= 1'b0;
        end
    end

endmodule

// File: tb/tb_arithmetic_unit.sv
// Scoreboard bench for arithmetic_unit: expectations are queued when an operation is
// driven and popped when the registered result appears after the next rising edge.
module tb_arithmetic_unit;

    typedef struct packed {
        logic [15:0] out;
        logic        cout;
        logic        flag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in1;
    logic [15:0] in2;
    logic [1:0]  arith_fun;
    logic        arith_en;
    logic [15:0] arith_out;
    logic        arith_cout;
    logic        arith_flag;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    arithmetic_unit #(
        .IN1_WIDTH      (16),
        .IN2_WIDTH      (16),
        .ARITH_OUT_WIDTH(16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in1       (in1),
        .in2       (in2),
        .arith_fun (arith_fun),
        .arith_en  (arith_en),
        .arith_out (arith_out),
        .arith_cout(arith_cout),
        .arith_flag(arith_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic exp_t model(input logic en, input logic [1:0] fun,
                                   input logic [15:0] a, input logic [15:0] b);
        exp_t        e;
        logic [31:0] r;
        e = '0;
        if (!en)
            return e;
        e.flag = 1'b1;
        case (fun)
            2'b00: begin
                r = {16'd0, a} + {16'd0, b};
                e.out = r[15:0];
                e.cout = (r > 32'd65535);
            end
            2'b01: begin
                r = {16'd0, a} - {16'd0, b};
                e.out = r[15:0];
                e.cout = (a < b);
            end
            2'b10: begin
                r = {16'd0, a} * {16'd0, b};
                e.out = r[15:0];
                e.cout = (r > 32'd65535);
            end
            default: begin
                if (b == 16'd0) begin
                    e.out = 16'hFFFF;
                    e.cout = 1'b1;
                end else begin
                    e.out = a / b;
                    e.cout = 1'b0;
                end
            end
        endcase
        return e;
    endfunction

    // Drive at the falling edge, queue the expectation, compare just after the rising edge.
    task automatic apply(input string tag, input logic en, input logic [1:0] fun,
                         input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        @(negedge clk);
        arith_en  = en;
        arith_fun = fun;
        in1       = a;
        in2       = b;
        exp_q.push_back(model(en, fun, a, b));
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_out"},  32'(arith_out),  32'(e.out));
            check({tag, "_cout"}, 32'(arith_cout), 32'(e.cout));
            check({tag, "_flag"}, 32'(arith_flag), 32'(e.flag));
        end
    endtask

    initial begin
        rst       = 1'b1;
        arith_en  = 1'b0;
        arith_fun = 2'b00;
        in1       = '0;
        in2       = '0;
        #12;
        check("rst_out",  32'(arith_out),  32'd0);
        check("rst_cout", 32'(arith_cout), 32'd0);
        check("rst_flag", 32'(arith_flag), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        apply("add",      1'b1, 2'b00, 16'd17,    16'd12);
        apply("sub",      1'b1, 2'b01, 16'd17,    16'd12);
        apply("sub_brw",  1'b1, 2'b01, 16'd12,    16'd17);
        apply("add_cy",   1'b1, 2'b00, 16'hFFFF,  16'd1);
        apply("mul_ovf",  1'b1, 2'b10, 16'd300,   16'd300);
        apply("mul",      1'b1, 2'b10, 16'd7,     16'd6);
        apply("div",      1'b1, 2'b11, 16'd17,    16'd5);
        apply("div_zero", 1'b1, 2'b11, 16'd17,    16'd0);
        apply("dis",      1'b0, 2'b00, 16'd17,    16'd12);
        apply("sub_eq",   1'b1, 2'b01, 16'h8000,  16'h8000);
        apply("mul_max",  1'b1, 2'b10, 16'hFFFF,  16'hFFFF);
        apply("div_max",  1'b1, 2'b11, 16'hFFFF,  16'd1);

        for (int i = 0; i < 40; i++) begin
            logic [15:0] a;
            logic [15:0] b;
            a = 16'($urandom);
            b = (i % 8 == 0) ? 16'd0 : 16'($urandom_range(0, (i % 2) ? 255 : 65535));
            apply("rand", ($urandom_range(0, 4) != 0), 2'($urandom_range(0, 3)), a, b);
        end

        // Asynchronous reset in the middle of a cycle after an enabled add
        apply("pre_rst", 1'b1, 2'b00, 16'd100, 16'd23);
        #2;
        rst = 1'b1;
        #1;
        check("async_out",  32'(arith_out),  32'd0);
        check("async_cout", 32'(arith_cout), 32'd0);
        check("async_flag", 32'(arith_flag), 32'd0);
        @(posedge clk);
        #1;
        check("held_flag", 32'(arith_flag), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        apply("post_rst", 1'b1, 2'b00, 16'd17, 16'd12);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, checks %0d", n_checks);
        $fatal(1, "timeout");
    end

endmodule
